lc3b_mem_ctrl: RTL and testbench
================================

# lc3b_mem_ctrl

Sequencer for the LC-3b memory-side datapath (MAR, MDR, store byte mux, load sign-extend, IR). Accepts one fetch/load/store request at a time from the control path and drives the MAR/MDR/IR load strobes, the MDR mux select and sext8 control. Runs the ready handshake with a multi-cycle memory and returns one response per request. A wait timeout turns a hung access into an error response.

## Interface
- `TIMEOUT`, 15: maximum ACCESS cycles without `mem_r` before the access is aborted; 0 disables the timeout.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle; a request is accepted when `req_valid && req_ready`.
- `req_op`  in  2  00 fetch, 01 load, 10 store, 11 reserved.
- `req_byte`  in  1  byte access; ignored for fetch.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data; a byte store uses `[7:0]`.
- `resp_valid`  out  1  one-cycle response pulse; cannot be back-pressured.
- `resp_data`  out  16  load/fetch data; a byte load is sign-extended.
- `resp_err`  out  1  qualifies `resp_valid`.
- `mem_en`  out  1  memory access active.
- `mem_we`  out  2  byte write enables: `[1]` high byte, `[0]` low byte.
- `mem_addr`  out  16  word address; bit 0 is forced to 0.
- `mem_wdata`  out  16  write data.
- `mem_rdata`  in  16  read data; valid when `mem_r` is high.
- `mem_r`  in  1  memory ready.
- `ld_mar`, `ld_mdr`, `ld_ir`  out  1 each  datapath load strobes.
- `mdr_mux_ctrl`  out  2  00 byte store, 01 word store, 10 to DR, 11 to IR.
- `sext8_ctrl`  out  1  high for byte loads.

## Operation
- **States:** IDLE, ADDR, ACCESS, RESP.
- **IDLE**
  - `req_ready`=1.
  - On accept, latch op, byte, addr and wdata.
  - Reserved op, or a word access with `addr[0]`=1, goes directly to RESP with error. No strobes and no memory access.
  - Any other request goes to ADDR.
- **ADDR:** `ld_mar`=1 for one cycle, then go to ACCESS.
- **ACCESS**
  - `mem_en`=1.
  - `mem_addr`, `mem_we` and `mem_wdata` are held stable until `mem_r` is sampled high.
  - Reads: `mem_we`=00. `ld_mdr`=1 in the cycle `mem_r` is high, and `mem_rdata` is captured internally.
  - Word store: `mem_we`=11, `mem_wdata`=wdata, `mdr_mux_ctrl`=01.
  - Byte store: `mem_we`=10 if `addr[0]` else 01; `mem_wdata`={wdata[7:0], wdata[7:0]}; `mdr_mux_ctrl`=00.
  - `mem_r` high goes to RESP.
  - Timeout goes to RESP with error, and `mem_en` drops in the next cycle.
- **RESP**
  - `resp_valid`=1 for one cycle, then go to IDLE.
  - Fetch: `ld_ir`=1, `mdr_mux_ctrl`=11, `resp_data`=word.
  - Word load: `resp_data`=word.
  - Byte load: `resp_data`=sext(addr[0] ? word[15:8] : word[7:0]), with `sext8_ctrl`=1 and `mdr_mux_ctrl`=10.
  - Store: `resp_data`=0.
  - Error: `resp_data`=0, `resp_err`=1.
- **Defaults:** `mdr_mux_ctrl`=10 in all other cycles; `mem_r` outside ACCESS is ignored.
- **Wait counter:** counts ACCESS cycles and clears on entry to ACCESS. Timeout fires when the count reaches `TIMEOUT` with `mem_r` low. `mem_r` high in the same cycle as the timeout wins, and no error is reported.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; `mdr_mux_ctrl`=10; all other outputs 0.
- **Minimum latency:** accept at cycle 0, ADDR at cycle 1, ACCESS at cycle 2 (`mem_r` high), `resp_valid` at cycle 3. Each extra wait cycle adds one.
- **Error-without-access latency:** `resp_valid` at cycle 1.
- **Throughput:** next accept no earlier than the cycle after RESP, because `req_ready` is low outside IDLE.
- **Reset mid-operation:** asynchronous return to IDLE. `mem_en`, strobes and `resp_valid` drop immediately; the in-flight request is discarded with no response.
- **Registered outputs:** all outputs are registered or decoded from registered state only. No combinational path runs from `mem_r` or `req_*` to any output except `ld_mdr`, which is gated by `mem_r` in ACCESS.

## Structure
- **Package `lc3b_mem_pkg`:** op encodings, the `mdr_mux_ctrl` encodings, and the state enum.
- **Sub-module `mem_wait_timer`:** the parameterised wait counter. Counter width is `$clog2(TIMEOUT+1)`, minimum 1. Inputs are clear and enable; output is `expired`.

## Test plan
- **Fetch:** addr 0x3000, `mem_r` on first ACCESS cycle, rdata 0x1234 -> `ld_mar` at cycle 1, `ld_mdr` at cycle 2, `resp_valid` + `ld_ir` at cycle 3, `resp_data`=0x1234, `mdr_mux_ctrl`=11.
- **Byte load:** addr 0x4001, rdata 0x80FF -> `resp_data`=0xFF80, `sext8_ctrl`=1. The same access at addr 0x4000 -> 0xFFFF.
- **Byte store:** addr 0x5001, wdata 0x00AB, 3 wait cycles -> `mem_we`=10, `mem_wdata`=0xABAB held for 4 ACCESS cycles, `resp_valid` at cycle 6, `resp_err`=0.
- **Word load at odd address:** addr 0x6003 -> `resp_err`=1 at cycle 1, `mem_en` never asserted. Reserved op 11 gives the same result.
- **Timeout:** `TIMEOUT`=4, `mem_r` held low -> `mem_en` high for 5 cycles, `resp_err`=1, `resp_data`=0. Then a normal request succeeds.
- **Reset mid-access:** `rst_n` low during ACCESS -> outputs at reset values immediately, no `resp_valid`. After release, `req_ready`=1 and a new request completes normally.

Source files
------------

// File: rtl/lc3b_mem_pkg.sv
// Shared encodings for the LC-3b memory-side sequencer: request ops, MDR mux selects
// and FSM states.
package lc3b_mem_pkg;

  typedef enum logic [1:0] {
    OpFetch = 2'b00,
    OpLoad  = 2'b01,
    OpStore = 2'b10,
    OpRsvd  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    MdrByteSt = 2'b00,
    MdrWordSt = 2'b01,
    MdrToDr   = 2'b10,
    MdrToIr   = 2'b11
  } mdr_mux_e;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StAccess,
    StResp
  } state_e;

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating ACCESS-cycle counter; expired flags the cycle whose count equals TIMEOUT.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != Limit)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A zero TIMEOUT disables the abort entirely.
  assign expired = (TIMEOUT != 0) && enable && (cnt_q == Limit);

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory-side sequencer: one request at a time through MAR load, memory handshake
// and a single-cycle response, with misalignment and wait-timeout errors.
module lc3b_mem_ctrl
  import lc3b_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_byte,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        mem_en,
  output logic [1:0]  mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic        ld_mar,
  output logic        ld_mdr,
  output logic        ld_ir,
  output logic [1:0]  mdr_mux_ctrl,
  output logic        sext8_ctrl
);

  state_e      state_q, state_d;
  op_e         op_q, op_d;
  logic        byte_q, byte_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] word_q, word_d;
  logic        err_q, err_d;
  logic        expired;
  logic        bad_req;
  logic        is_store;
  mdr_mux_e    mux_sel;

  // Fetches and non-byte accesses must be word aligned; the reserved op is always rejected.
  assign bad_req  = (op_e'(req_op) == OpRsvd) ||
                    (((op_e'(req_op) == OpFetch) || !req_byte) && req_addr[0]);
  assign is_store = (op_q == OpStore);

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == StAddr),
    .enable (state_q == StAccess),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d    = op_e'(req_op);
          byte_d  = req_byte;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = bad_req;
          state_d = bad_req ? StResp : StAddr;
        end
      end
      StAddr: state_d = StAccess;
      StAccess: begin
        // Ready in the timeout cycle wins over the abort.
        if (mem_r) begin
          if (!is_store) begin
            word_d = mem_rdata;
          end
          state_d = StResp;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      op_q    <= OpFetch;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = 1'b0;
    resp_data  = '0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 2'b00;
    mem_addr   = '0;
    mem_wdata  = '0;
    ld_mar     = 1'b0;
    ld_mdr     = 1'b0;
    ld_ir      = 1'b0;
    sext8_ctrl = 1'b0;
    mux_sel    = MdrToDr;
    unique case (state_q)
      StIdle: ;
      StAddr: ld_mar = 1'b1;
      StAccess: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[15:1], 1'b0};
        if (is_store) begin
          if (byte_q) begin
            mem_we    = addr_q[0] ? 2'b10 : 2'b01;
            mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
            mux_sel   = MdrByteSt;
          end else begin
            mem_we    = 2'b11;
            mem_wdata = wdata_q;
            mux_sel   = MdrWordSt;
          end
        end else begin
          ld_mdr = mem_r;
        end
      end
      StResp: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (!err_q) begin
          unique case (op_q)
            OpFetch: begin
              ld_ir     = 1'b1;
              mux_sel   = MdrToIr;
              resp_data = word_q;
            end
            OpLoad: begin
              if (byte_q) begin
                sext8_ctrl = 1'b1;
                resp_data  = sext8(addr_q[0] ? word_q[15:8] : word_q[7:0]);
              end else begin
                resp_data = word_q;
              end
            end
            default: resp_data = '0;
          endcase
        end
      end
      default: ;
    endcase
    mdr_mux_ctrl = mux_sel;
  end

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Scoreboard bench for lc3b_mem_ctrl: directed cases plus randomized requests against a
// word-array reference model and a bus-functional memory.
module tb_lc3b_mem_ctrl;

  localparam int unsigned TO = 4;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_byte;
  logic [1:0]  req_op;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [15:0] resp_data;
  logic        mem_en, mem_r;
  logic [1:0]  mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        ld_mar, ld_mdr, ld_ir, sext8_ctrl;
  logic [1:0]  mdr_mux_ctrl;

  lc3b_mem_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_r(mem_r),
    .ld_mar(ld_mar), .ld_mdr(ld_mdr), .ld_ir(ld_ir),
    .mdr_mux_ctrl(mdr_mux_ctrl), .sext8_ctrl(sext8_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        ir;
    logic [1:0]  mux;
    logic        sx;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  we;
    logic [15:0] wd;
    int          wt;
  } bus_t;

  resp_t       sbq[$];
  bus_t        busq[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] tb_mem[logic [15:0]];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [15:0] wa);
    return wa ^ 16'hC35A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [15:0] wa);
    return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
  endfunction

  function automatic logic [15:0] tb_rd(input logic [15:0] wa);
    return tb_mem.exists(wa) ? tb_mem[wa] : init_word(wa);
  endfunction

  // Reference model + driver: op 0 fetch, 1 load, 2 store, 3 reserved; wt = ready delay.
  task automatic issue(input logic [1:0] op, input logic byt, input logic [15:0] addr,
                       input logic [15:0] wd, input int wt, input bit abort);
    resp_t       r;
    bus_t        b;
    logic [15:0] wa, w;
    logic [7:0]  bb;
    int          lat, n;
    bit          noacc, tmo;
    wa    = {addr[15:1], 1'b0};
    noacc = (op == 2'd3) || (((op == 2'd0) || !byt) && addr[0]);
    tmo   = (wt > int'(TO));
    r.data = 16'h0; r.err = 1'b1; r.ir = 1'b0; r.mux = 2'b10; r.sx = 1'b0;
    if (noacc) begin
      lat = 1;
    end else begin
      lat    = tmo ? int'(TO) + 3 : wt + 3;
      b.addr = wa;
      b.we   = (op == 2'd2) ? (byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11) : 2'b00;
      b.wd   = byt ? {wd[7:0], wd[7:0]} : wd;
      b.wt   = wt;
      busq.push_back(b);
      if (!tmo) begin
        w     = ref_rd(wa);
        r.err = 1'b0;
        case (op)
          2'd0: begin r.data = w; r.ir = 1'b1; r.mux = 2'b11; end
          2'd1: begin
            if (byt) begin
              bb     = addr[0] ? w[15:8] : w[7:0];
              r.data = {{8{bb[7]}}, bb};
              r.sx   = 1'b1;
            end else begin
              r.data = w;
            end
          end
          default: begin
            if (!byt) w = wd;
            else if (addr[0]) w[15:8] = wd[7:0];
            else w[7:0] = wd[7:0];
            if (!abort) ref_mem[wa] = w;
          end
        endcase
      end
    end
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_byte = byt; req_addr = addr; req_wdata = wd;
    r.cyc = cyc + lat;
    if (!abort) sbq.push_back(r);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    @(negedge clk);
    check("ld_mar", 32'(ld_mar), 32'(!noacc));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    if (abort) return;
    n = 0;
    while (sbq.size() != 0 && n < 40) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      check("resp_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
  endtask

  // Monitor: every response pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    resp_t e;
    if (rst_n && resp_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got data %0h err %0b expected none", resp_data, resp_err);
      end else begin
        e = sbq.pop_front();
        check("resp_data", 32'(resp_data), 32'(e.data));
        check("resp_err", 32'(resp_err), 32'(e.err));
        check("ld_ir", 32'(ld_ir), 32'(e.ir));
        check("mdr_mux_resp", 32'(mdr_mux_ctrl), 32'(e.mux));
        check("sext8_ctrl", 32'(sext8_ctrl), 32'(e.sx));
        check("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Bus-functional memory: raises mem_r after the scheduled wait, checks bus stability.
  bus_t cur;
  bit   in_acc = 1'b0;
  bit   have = 1'b0;
  int   acc = 0;
  always @(negedge clk) begin
    logic [15:0] w;
    if (!rst_n) begin
      in_acc = 1'b0; have = 1'b0; mem_r = 1'b0;
    end else if (mem_en) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        acc    = 0;
        have   = (busq.size() != 0);
        if (have) cur = busq.pop_front();
        else begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_mem_en: got mem_en 1 at addr %0h expected 0", mem_addr);
        end
      end
      if (have) begin
        check("mem_addr", 32'(mem_addr), 32'(cur.addr));
        check("mem_we", 32'(mem_we), 32'(cur.we));
        if (cur.we != 2'b00) begin
          check("mem_wdata", 32'(mem_wdata), 32'(cur.wd));
          check("mdr_mux_store", 32'(mdr_mux_ctrl), (cur.we == 2'b11) ? 32'd1 : 32'd0);
        end
        if (acc == cur.wt) begin
          mem_r     = 1'b1;
          w         = tb_rd(cur.addr);
          mem_rdata = w;
          if (mem_we[1]) w[15:8] = mem_wdata[15:8];
          if (mem_we[0]) w[7:0] = mem_wdata[7:0];
          tb_mem[cur.addr] = w;
        end else begin
          mem_r     = 1'b0;
          mem_rdata = 16'($urandom);
        end
        acc++;
        #1;
        check("ld_mdr", 32'(ld_mdr), 32'(mem_r && (cur.we == 2'b00)));
      end
    end else begin
      in_acc    = 1'b0;
      mem_r     = 1'($urandom_range(0, 1));
      mem_rdata = 16'($urandom);
    end
  end

  initial begin
    int          sel;
    logic [1:0]  op;
    logic        byt;
    logic [15:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; mem_r = 1'b0; mem_rdata = '0;
    ref_mem[16'h3000] = 16'h1234; tb_mem[16'h3000] = 16'h1234;
    ref_mem[16'h4000] = 16'h80FF; tb_mem[16'h4000] = 16'h80FF;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mdr_mux", 32'(mdr_mux_ctrl), 32'd2);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;

    issue(2'd0, 1'b0, 16'h3000, 16'h0000, 0, 1'b0);
    issue(2'd1, 1'b1, 16'h4001, 16'h0000, 0, 1'b0);
    issue(2'd1, 1'b1, 16'h4000, 16'h0000, 0, 1'b0);
    issue(2'd2, 1'b1, 16'h5001, 16'h00AB, 3, 1'b0);
    issue(2'd1, 1'b0, 16'h5000, 16'h0000, 0, 1'b0);
    issue(2'd1, 1'b0, 16'h6003, 16'h0000, 0, 1'b0);
    issue(2'd3, 1'b0, 16'h4000, 16'h0000, 0, 1'b0);
    issue(2'd1, 1'b0, 16'h4002, 16'h0000, 6, 1'b0);
    issue(2'd1, 1'b0, 16'h4002, 16'h0000, 4, 1'b0);
    issue(2'd2, 1'b0, 16'h4004, 16'hBEEF, 5, 1'b0);
    issue(2'd1, 1'b0, 16'h4004, 16'h0000, 1, 1'b0);

    // Abort a load mid-ACCESS with an asynchronous reset.
    issue(2'd1, 1'b0, 16'h4010, 16'h0000, 3, 1'b1);
    @(negedge clk);
    check("abort_in_access", 32'(mem_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_en", 32'(mem_en), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_ld_mdr", 32'(ld_mdr), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_mdr_mux", 32'(mdr_mux_ctrl), 32'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_ready", 32'(req_ready), 32'd1);
    issue(2'd0, 1'b0, 16'h3000, 16'h0000, 2, 1'b0);

    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 3) ? 2'd0 : (sel < 6) ? 2'd1 : (sel < 9) ? 2'd2 : 2'd3;
      byt = 1'($urandom_range(0, 1));
      a   = 16'h4000 + 16'($urandom_range(0, 31));
      if (((op == 2'd0) || !byt) && ($urandom_range(0, 3) != 0)) a[0] = 1'b0;
      issue(op, byt, a, 16'($urandom), $urandom_range(0, 6), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("busq_drained", 32'(busq.size()), 32'd0);
    check("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
